// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and duty word type for the four-channel PWM block
package pwm_pkg;

    localparam int          NUM_CH        = 4;
    localparam logic [11:0] PWM_BASE_ADDR = 12'd1000;
    localparam int          ENABLE_BIT    = 31;

    typedef logic [31:0] duty_t;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: shadow duty, comparator, output flop; PWM_CH_ENABLE_EN adds a per-channel enable bit
import pwm_pkg::*;

module pwm_channel #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrap,
    input  logic [CNT_WIDTH-1:0] cnt,
    input  duty_t                duty,
    output logic                 pwm
);

    duty_t       shadow;
    logic        enable;
    logic [31:0] level;

`ifdef PWM_CH_ENABLE_EN
    assign enable = shadow[ENABLE_BIT];
    assign level  = {1'b0, shadow[ENABLE_BIT-1:0]};
`else
    assign enable = 1'b1;
    assign level  = shadow;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (wrap) begin
            shadow <= duty;
        end
    end

    // Full-width compare so duties at or above the period hold the pin high across the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm <= 1'b0;
        end else begin
            pwm <= enable && (32'(cnt) < level);
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - four-channel PWM with shared prescaler and period counter; optional PWM_CH_ENABLE_EN
import pwm_pkg::*;

module pwm_generator #(
    parameter int PRESCALE  = 1,
    parameter int PERIOD    = 1000,
    parameter int CNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  duty_t             pwm0,
    input  duty_t             pwm1,
    input  duty_t             pwm2,
    input  duty_t             pwm3,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam int                   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]        PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(PERIOD - 1);

    logic [PW-1:0]        presc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 tick;
    logic                 wrap;
    duty_t                duty [NUM_CH];

    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
        end
    end

    assign duty[0] = pwm0;
    assign duty[1] = pwm1;
    assign duty[2] = pwm2;
    assign duty[3] = pwm3;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .wrap  (wrap),
            .cnt   (cnt),
            .duty  (duty[i]),
            .pwm   (pwm_out[i])
        );
    end

endmodule
